// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: a West requester and an East requester share one
// logic/arithmetic unit. Arbitration is round-robin with valid/ready
// handshakes. Only one operation is in flight at a time. The registered
// result goes out on one response channel, tagged with its source.
module alu_share_arbiter #(
  parameter int unsigned     DW        = 36,
  parameter int unsigned     CW        = 16,
  parameter logic [DW-1:0]   CONST_VAL = 36'h0_DEAD_BEEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [2:0]    w_op,
  input  logic [DW-1:0] w_opa,
  input  logic [DW-1:0] w_opb,
  input  logic          e_valid,
  output logic          e_ready,
  input  logic [2:0]    e_op,
  input  logic [DW-1:0] e_opa,
  input  logic [DW-1:0] e_opb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_src,
  output logic          rsp_carry,
  output logic          rsp_zero,
  output logic          rsp_err,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_XOR   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_CONST = 3'd5;

  state_t        state, state_nx;
  logic          rr_next;       // 0 = West has priority, 1 = East
  logic          gnt_w, gnt_e;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q;
  logic          src_q;
  logic [DW-1:0] alu_data;
  logic          alu_carry, alu_err;
  logic [DW:0]   sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_w || gnt_e) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: round-robin grant in IDLE only, response valid while in RESP.
  // The readies are gated by reset, so reset never shows a grant.
  always_comb begin
    gnt_w     = 1'b0;
    gnt_e     = 1'b0;
    if (state == IDLE && rst_n) begin
      gnt_w = w_valid && (!e_valid || !rr_next);
      gnt_e = e_valid && (!w_valid ||  rr_next);
    end
    w_ready   = gnt_w;
    e_ready   = gnt_e;
    rsp_valid = (state == RESP);
  end

  // Shared ALU, fed from the captured operands
  always_comb begin
    alu_data  = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    sum       = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      OP_XOR:   alu_data = a_q ^ b_q;
      OP_AND:   alu_data = a_q & b_q;
      OP_OR:    alu_data = a_q | b_q;
      OP_ADD: begin
        alu_data  = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      OP_SUB: begin
        alu_data  = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_CONST: alu_data = CONST_VAL;
      default:  alu_err = 1'b1;
    endcase
  end

  // Capture on grant, register the result in EXEC, count response handshakes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_next   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      src_q     <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (gnt_w) begin
        op_q    <= w_op;
        a_q     <= w_opa;
        b_q     <= w_opb;
        src_q   <= 1'b0;
        rr_next <= 1'b1;
      end else if (gnt_e) begin
        op_q    <= e_op;
        a_q     <= e_opa;
        b_q     <= e_opb;
        src_q   <= 1'b1;
        rr_next <= 1'b0;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_data;
        rsp_src   <= src_q;
        rsp_carry <= alu_carry;
        rsp_zero  <= (alu_data == '0);
        rsp_err   <= alu_err;
      end
      if (state == RESP && rsp_ready)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter. Inputs are driven and outputs
// are sampled on the falling clock edge.
module tb_alu_share_arbiter;

  localparam int unsigned DW = 36;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_valid, e_valid, rsp_ready;
  logic          w_ready, e_ready;
  logic [2:0]    w_op, e_op;
  logic [DW-1:0] w_opa, w_opb, e_opa, e_opb;
  logic          rsp_valid, rsp_src, rsp_carry, rsp_zero, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.DW(DW), .CW(CW), .CONST_VAL(36'h0_DEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_op(w_op), .w_opa(w_opa), .w_opb(w_opb),
    .e_valid(e_valid), .e_ready(e_ready), .e_op(e_op), .e_opa(e_opa), .e_opb(e_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_valid = 1'b1; e_valid = 1'b1; rsp_ready = 1'b1;
    w_op = 3'd0; w_opa = '0; w_opb = '0; e_op = 3'd0; e_opa = '0; e_opb = '0;
    @(posedge clk); tick();
    checks++; if ({rsp_valid, rsp_src, rsp_carry, rsp_zero, rsp_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {rsp_valid, rsp_src, rsp_carry, rsp_zero, rsp_err}); end
    checks++; if ({w_ready, e_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {w_ready, e_ready}); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rsp_data); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", op_count); end
    rst_n = 1'b1; #1;
    checks++; if ({w_ready, e_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_grant: got %b expected 10", {w_ready, e_ready}); end
    w_valid = 1'b0; e_valid = 1'b0; #1;
    tick();
  endtask

  task automatic test_add_carry();
    w_valid = 1'b1; w_op = 3'd3; w_opa = 36'hF_FFFF_FFFF; w_opb = 36'h1; rsp_ready = 1'b1; #1;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL add_wready: got %b expected 1", w_ready); end
    tick(); w_valid = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_latency_n1: got %b expected 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid_n2: got %b expected 1", rsp_valid); end
    checks++; if ({rsp_data, rsp_carry, rsp_zero, rsp_src, rsp_err} !== {36'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL add_result: got data=%h c=%b z=%b s=%b e=%b expected data=0 c=1 z=1 s=0 e=0", rsp_data, rsp_carry, rsp_zero, rsp_src, rsp_err); end
    tick();
    checks++; if ({rsp_valid, op_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL add_count: got v=%b cnt=%0d expected v=0 cnt=1", rsp_valid, op_count); end
  endtask

  // West was granted last, so East has priority for the first contested grant.
  task automatic test_alternate();
    logic exp_src = 1'b1;
    int   cyc;
    w_valid = 1'b1; w_op = 3'd0; w_opa = 36'h0_0000_00A5; w_opb = 36'h0_0000_000F;
    e_valid = 1'b1; e_op = 3'd4; e_opa = 36'd5; e_opb = 36'd7; rsp_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (!rsp_valid && cyc < 10) begin
        checks++; if ((w_ready & e_ready) !== 1'b0) begin errors++; $display("FAIL alt_both_ready: got 1 expected 0"); end
        tick(); cyc++;
      end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL alt_timeout: got rsp_valid=%b expected 1", rsp_valid); end
      checks++; if (rsp_src !== exp_src) begin errors++; $display("FAIL alt_src[%0d]: got %b expected %b", i, rsp_src, exp_src); end
      if (exp_src) begin
        checks++; if ({rsp_data, rsp_carry} !== {36'hF_FFFF_FFFE, 1'b1}) begin errors++; $display("FAIL alt_sub: got %h c=%b expected fffffffe c=1", rsp_data, rsp_carry); end
      end else begin
        checks++; if ({rsp_data, rsp_carry} !== {36'h0_0000_00AA, 1'b0}) begin errors++; $display("FAIL alt_xor: got %h c=%b expected aa c=0", rsp_data, rsp_carry); end
      end
      exp_src = ~exp_src;
      if (i == 3) begin w_valid = 1'b0; e_valid = 1'b0; end
      tick();
    end
    checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL alt_count: got %0d expected 5", op_count); end
  endtask

  task automatic test_hold();
    e_valid = 1'b1; e_op = 3'd5; e_opa = 36'h1_2345_6789; e_opb = 36'h9_8765_4321; rsp_ready = 1'b0; #1;
    checks++; if (e_ready !== 1'b1) begin errors++; $display("FAIL hold_eready: got %b expected 1", e_ready); end
    tick(); e_valid = 1'b0; w_valid = 1'b1; w_op = 3'd0; #1;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if ({rsp_valid, rsp_src, rsp_data, rsp_carry, rsp_zero, rsp_err} !== {1'b1, 1'b1, 36'h0_DEAD_BEEF, 3'b000}) begin errors++; $display("FAIL hold_rsp[%0d]: got v=%b s=%b d=%h expected v=1 s=1 d=deadbeef", i, rsp_valid, rsp_src, rsp_data); end
      checks++; if ({w_ready, e_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 00", i, {w_ready, e_ready}); end
      checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL hold_count[%0d]: got %0d expected 5", i, op_count); end
      tick();
    end
    rsp_ready = 1'b1; w_valid = 1'b0; #1;
    tick();
    checks++; if ({rsp_valid, op_count} !== {1'b0, 16'd6}) begin errors++; $display("FAIL hold_release: got v=%b cnt=%0d expected v=0 cnt=6", rsp_valid, op_count); end
  endtask

  task automatic test_illegal();
    w_valid = 1'b1; w_op = 3'd7; w_opa = 36'h0_0000_0123; w_opb = 36'h0_0000_0456; rsp_ready = 1'b1; #1;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL ill_wready: got %b expected 1", w_ready); end
    tick(); w_valid = 1'b0; #1;
    tick();
    checks++; if ({rsp_valid, rsp_data, rsp_err, rsp_zero, rsp_carry, rsp_src} !== {1'b1, 36'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL ill_result: got v=%b d=%h e=%b z=%b c=%b expected v=1 d=0 e=1 z=1 c=0", rsp_valid, rsp_data, rsp_err, rsp_zero, rsp_carry); end
    tick();
    checks++; if (op_count !== 16'd7) begin errors++; $display("FAIL ill_count: got %0d expected 7", op_count); end
  endtask

  // Remaining opcodes from East, including ADD without carry and a zero SUB.
  task automatic test_ops();
    logic [2:0]    t_op [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [DW-1:0] t_a  [4] = '{36'hF_0F0F_0F0F, 36'h0_F000_000F, 36'h7_FFFF_FFFF, 36'h0_0000_1234};
    logic [DW-1:0] t_b  [4] = '{36'h3_3333_3333, 36'h1_0000_0100, 36'h0_0000_0001, 36'h0_0000_1234};
    logic [DW-1:0] t_d  [4] = '{36'h3_0303_0303, 36'h1_F000_010F, 36'h8_0000_0000, 36'h0};
    logic          t_z  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      e_valid = 1'b1; e_op = t_op[i]; e_opa = t_a[i]; e_opb = t_b[i]; #1;
      tick(); e_valid = 1'b0; #1;
      tick();
      checks++; if ({rsp_valid, rsp_src, rsp_data, rsp_carry, rsp_zero, rsp_err} !== {1'b1, 1'b1, t_d[i], 1'b0, t_z[i], 1'b0}) begin errors++; $display("FAIL ops[%0d]: got v=%b s=%b d=%h c=%b z=%b e=%b expected d=%h z=%b", i, rsp_valid, rsp_src, rsp_data, rsp_carry, rsp_zero, rsp_err, t_d[i], t_z[i]); end
      tick();
    end
    checks++; if (op_count !== 16'd11) begin errors++; $display("FAIL ops_count: got %0d expected 11", op_count); end
  endtask

  task automatic test_reset_mid();
    w_valid = 1'b1; w_op = 3'd0; w_opa = 36'h5; w_opb = 36'h3; rsp_ready = 1'b1; #1;
    tick(); w_valid = 1'b0; rst_n = 1'b0; #1;
    tick(); rst_n = 1'b1; #1;
    checks++; if ({rsp_valid, op_count} !== {1'b0, 16'd0}) begin errors++; $display("FAIL rst_exec: got v=%b cnt=%0d expected v=0 cnt=0", rsp_valid, op_count); end
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_norsp: got %b expected 0", rsp_valid); end
    w_valid = 1'b1; rsp_ready = 1'b0; #1;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_next: got %b expected 1", w_ready); end
    tick(); w_valid = 1'b0; #1;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got %b expected 1", rsp_valid); end
    rst_n = 1'b0; #1;
    tick(); rst_n = 1'b1; #1;
    checks++; if ({rsp_valid, op_count, rsp_data} !== {1'b0, 16'd0, 36'h0}) begin errors++; $display("FAIL rst_resp: got v=%b cnt=%0d d=%h expected v=0 cnt=0 d=0", rsp_valid, op_count, rsp_data); end
    w_valid = 1'b1; e_valid = 1'b1; e_op = 3'd5; rsp_ready = 1'b1; #1;
    checks++; if ({w_ready, e_ready} !== 2'b10) begin errors++; $display("FAIL rst_resp_next: got %b expected 10", {w_ready, e_ready}); end
    tick(); w_valid = 1'b0; e_valid = 1'b0; #1;
    tick();
    checks++; if ({rsp_valid, rsp_src, rsp_data} !== {1'b1, 1'b0, 36'h6}) begin errors++; $display("FAIL rst_after: got v=%b s=%b d=%h expected v=1 s=0 d=6", rsp_valid, rsp_src, rsp_data); end
    tick();
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_after_count: got %0d expected 1", op_count); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_alternate();
    test_hold();
    test_illegal();
    test_ops();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
